decode_control_unit: RTL and testbench
======================================

Name: decode_control_unit

Overview:
- Decode-stage control generator: the producer side of the Decode/Execute control bundle (wbs, wme, mm, ALUop, wm, am, ni).
- Decodes the ID-stage opcode into that bundle and drives it combinationally into the DE pipeline register.
- Owns pipeline sequencing: load-use stall, taken-branch flush, multi-cycle MUL occupancy and HALT, through a small registered FSM.
- Emits stall/flush to the IF and IF/ID stages.

Parameters:
REG_ADDR_W, 4, register-index width
MUL_CYCLES, 2, execute cycles for MUL (legal 1..8)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
valid_in  input  1  ID stage holds a real instruction
opcode_in  input  4  ID opcode
rs1_in  input  REG_ADDR_W  ID source 1
rs2_in  input  REG_ADDR_W  ID source 2
ex_mm_in  input  1  mm currently in EX (from DE register)
ex_wm_in  input  1  wm currently in EX
ex_rd_in  input  REG_ADDR_W  destination currently in EX
branch_taken_in  input  1  EX resolves taken branch this cycle
wbs_out  output  1  write-back select (0 ALU, 1 memory)
wme_out  output  1  data-memory write enable
mm_out  output  1  memory read
ALUop_out  output  2  00 add, 01 sub, 10 mul, 11 shl
wm_out  output  1  register-file write
am_out  output  1  ALU B operand (0 rs2, 1 immediate)
ni_out  output  1  branch instruction (PC redirect candidate)
stall_out  output  1  hold PC and IF/ID
flush_out  output  1  clear IF/ID
halted_out  output  1  core halted
illegal_out  output  1  undefined opcode in ID (one-cycle pulse per cycle present)
perf_stall_out  output  16  stall-cycle count (optional feature)
perf_flush_out  output  16  flush count (optional feature)

Behaviour:
- Decode table (unlisted bits 0). "Bubble" = all seven control outputs 0.
  - 0x0 NOP: bubble
  - 0x1 ADD: wm
  - 0x2 SUB: ALUop=01, wm
  - 0x3 ADDI: am, wm
  - 0x4 LDR: am, mm, wbs, wm
  - 0x5 STR: am, wme
  - 0x6 MUL: ALUop=10, wm
  - 0x7 SHL: ALUop=11, wm
  - 0x8 B: ni
  - 0xF HALT: bubble
  - Other opcodes: bubble, with illegal_out=1.
- Register use:
  - rs1 is used by 0x1-0x8.
  - rs2 is used by ADD, SUB, MUL, SHL and STR.
  - Register 0 never causes a hazard.
- Load-use hazard is combinational. It is asserted when all of the following hold: valid_in, ex_mm_in, ex_wm_in, ex_rd_in!=0, and ex_rd_in equals a used rs1 or rs2.
- FSM states: RUN, MUL_WAIT, HALTED. A 3-bit counter mul_cnt supports MUL_WAIT.
- Priority, evaluated each cycle:
  1. branch_taken_in: bubble, flush_out=1, stall_out=0. Next state RUN, mul_cnt cleared, HALT/MUL in ID discarded. This also applies in MUL_WAIT, but not in HALTED.
  2. HALTED: bubble, stall_out=1, halted_out=1. Exited only by reset.
  3. MUL_WAIT: bubble, stall_out=1, mul_cnt decrements. When mul_cnt==1, next state is RUN.
  4. Load-use hazard: bubble, stall_out=1 for exactly one cycle. The load advances, so the hazard self-clears.
  5. RUN decode with valid_in=1:
     - Emit the decode table.
     - HALT: next state HALTED.
     - MUL with MUL_CYCLES>1: next state MUL_WAIT, mul_cnt=MUL_CYCLES-1.
  6. valid_in=0: bubble, no state change.
- Control outputs, stall_out, flush_out and illegal_out are combinational from state and inputs. They are valid before the DE register samples on the rising edge.
- Latency from opcode to control outputs: 0 cycles. MUL occupies MUL_CYCLES issue slots (1 instruction + MUL_CYCLES-1 bubbles).
- Reset (asynchronous, any state, including mid-MUL_WAIT): state=RUN, mul_cnt=0, halted_out=0, perf counters 0. Other outputs follow the decode of the inputs in RUN.
- stall_out and flush_out are never both 1.

Optional Feature:
PERF_COUNTERS_EN
- Defined:
  - perf_stall_out increments on every cycle with stall_out=1, excluding HALTED.
  - perf_flush_out increments on every cycle with flush_out=1.
  - Both counters are 16-bit and saturate at 0xFFFF.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- Reset mid-MUL_WAIT (MUL_CYCLES=4, reset after 1 bubble) -> next cycle state RUN, stall_out=0, halted_out=0.
- ID=ADD rs1=3 rs2=5, EX: mm=1 wm=1 rd=5 -> 1 cycle bubble with stall_out=1; next cycle wm_out=1, ALUop_out=00.
- Same as above but rd=0, or ID=ADDI with rs2=5 -> no stall; ADDI gives am_out=1, wm_out=1.
- MUL, MUL_CYCLES=3 -> cycle0 ALUop_out=10, wm_out=1; cycles1-2 bubble with stall_out=1; cycle3 the next instruction decodes.
- ID=HALT with branch_taken_in=1 -> flush_out=1, no halt. Next cycle ID=HALT alone -> halted_out=1 and stall_out=1 held for 20 cycles despite branch_taken_in.
- With PERF_COUNTERS_EN: 3 load-use stalls + 2 flushes -> perf_stall_out=3, perf_flush_out=2. Forced 70000 stalls -> 0xFFFF.

Source files
------------

// File: rtl/decode_control_unit.sv
// decode_control_unit
// Decode-stage control generator. Turns the ID opcode into the Decode/Execute
// control bundle (wbs, wme, mm, ALUop, wm, am, ni) with zero latency. It also
// sequences the pipeline: load-use stall, taken-branch flush, multi-cycle MUL
// occupancy and HALT, using a small registered FSM.
//
// Optional feature macro: PERF_COUNTERS_EN
//   defined   -> 16-bit saturating stall-cycle and flush counters
//   undefined -> perf_stall_out / perf_flush_out tied to zero, no counter flops
//
// Handshake: there is no valid/ready pair here. valid_in qualifies the ID
// instruction; stall_out=1 means "ID was not consumed, hold PC and IF/ID";
// flush_out=1 means "discard IF/ID"; the two are never asserted together.
module decode_control_unit #(
    parameter int REG_ADDR_W = 4,
    parameter int MUL_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_in,
    input  logic [3:0]            opcode_in,
    input  logic [REG_ADDR_W-1:0] rs1_in,
    input  logic [REG_ADDR_W-1:0] rs2_in,
    input  logic                  ex_mm_in,
    input  logic                  ex_wm_in,
    input  logic [REG_ADDR_W-1:0] ex_rd_in,
    input  logic                  branch_taken_in,
    output logic                  wbs_out,
    output logic                  wme_out,
    output logic                  mm_out,
    output logic [1:0]            ALUop_out,
    output logic                  wm_out,
    output logic                  am_out,
    output logic                  ni_out,
    output logic                  stall_out,
    output logic                  flush_out,
    output logic                  halted_out,
    output logic                  illegal_out,
    output logic [15:0]           perf_stall_out,
    output logic [15:0]           perf_flush_out
);

    // FSM encoding
    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MUL_WAIT = 2'd1;
    localparam logic [1:0] ST_HALTED   = 2'd2;

    // Opcodes
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_ADDI = 4'h3;
    localparam logic [3:0] OP_LDR  = 4'h4;
    localparam logic [3:0] OP_STR  = 4'h5;
    localparam logic [3:0] OP_MUL  = 4'h6;
    localparam logic [3:0] OP_SHL  = 4'h7;
    localparam logic [3:0] OP_B    = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Bubbles still owed after a MUL issues (MUL itself takes the first slot)
    localparam logic [2:0] MUL_INIT = 3'(MUL_CYCLES - 1);

    logic [1:0] state_q, state_d;
    logic [2:0] mul_cnt_q, mul_cnt_d;

    // Raw decode of the ID opcode, before any sequencing override
    logic       dec_wbs, dec_wme, dec_mm, dec_wm, dec_am, dec_ni;
    logic [1:0] dec_aluop;
    logic       dec_illegal;
    logic       uses_rs1, uses_rs2;

    logic       load_use;
    logic       decode_en;

    // Opcode decode table and source-register usage
    always_comb begin
        dec_wbs     = 1'b0;
        dec_wme     = 1'b0;
        dec_mm      = 1'b0;
        dec_aluop   = 2'b00;
        dec_wm      = 1'b0;
        dec_am      = 1'b0;
        dec_ni      = 1'b0;
        dec_illegal = 1'b0;
        uses_rs1    = 1'b0;
        uses_rs2    = 1'b0;
        case (opcode_in)
            OP_NOP: ;
            OP_ADD: begin
                dec_wm   = 1'b1;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_SUB: begin
                dec_aluop = 2'b01;
                dec_wm    = 1'b1;
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
            end
            OP_ADDI: begin
                dec_am   = 1'b1;
                dec_wm   = 1'b1;
                uses_rs1 = 1'b1;
            end
            OP_LDR: begin
                dec_am   = 1'b1;
                dec_mm   = 1'b1;
                dec_wbs  = 1'b1;
                dec_wm   = 1'b1;
                uses_rs1 = 1'b1;
            end
            OP_STR: begin
                dec_am   = 1'b1;
                dec_wme  = 1'b1;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_MUL: begin
                dec_aluop = 2'b10;
                dec_wm    = 1'b1;
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
            end
            OP_SHL: begin
                dec_aluop = 2'b11;
                dec_wm    = 1'b1;
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
            end
            OP_B: begin
                dec_ni   = 1'b1;
                uses_rs1 = 1'b1;
            end
            OP_HALT: ;
            default: dec_illegal = 1'b1;
        endcase
    end

    // Load-use hazard: a load in EX writes a register that ID reads; r0 is exempt
    assign load_use = valid_in && ex_mm_in && ex_wm_in && (ex_rd_in != '0) &&
                      ((uses_rs1 && (rs1_in == ex_rd_in)) ||
                       (uses_rs2 && (rs2_in == ex_rd_in)));

    // Sequencing priority: branch flush, halted, MUL occupancy, load-use, decode
    always_comb begin
        state_d   = state_q;
        mul_cnt_d = mul_cnt_q;
        stall_out = 1'b0;
        flush_out = 1'b0;
        decode_en = 1'b0;
        if (branch_taken_in && (state_q != ST_HALTED)) begin
            // Wrong-path instruction in ID is dropped, including HALT/MUL
            flush_out = 1'b1;
            state_d   = ST_RUN;
            mul_cnt_d = 3'd0;
        end else if (state_q == ST_HALTED) begin
            stall_out = 1'b1;
        end else if (state_q == ST_MUL_WAIT) begin
            stall_out = 1'b1;
            mul_cnt_d = mul_cnt_q - 3'd1;
            if (mul_cnt_q == 3'd1) begin
                state_d = ST_RUN;
            end
        end else if (load_use) begin
            // The load moves on next cycle, so this clears by itself
            stall_out = 1'b1;
        end else if (valid_in) begin
            decode_en = 1'b1;
            if (opcode_in == OP_HALT) begin
                state_d = ST_HALTED;
            end else if ((opcode_in == OP_MUL) && (MUL_CYCLES > 1)) begin
                state_d   = ST_MUL_WAIT;
                mul_cnt_d = MUL_INIT;
            end
        end
    end

    // Control bundle is the decode only when the instruction actually issues
    assign wbs_out     = decode_en & dec_wbs;
    assign wme_out     = decode_en & dec_wme;
    assign mm_out      = decode_en & dec_mm;
    assign ALUop_out   = decode_en ? dec_aluop : 2'b00;
    assign wm_out      = decode_en & dec_wm;
    assign am_out      = decode_en & dec_am;
    assign ni_out      = decode_en & dec_ni;
    assign illegal_out = decode_en & dec_illegal;
    assign halted_out  = (state_q == ST_HALTED);

    // FSM and MUL counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            mul_cnt_q <= 3'd0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

`ifdef PERF_COUNTERS_EN
    logic [15:0] perf_stall_q, perf_stall_d;
    logic [15:0] perf_flush_q, perf_flush_d;

    // Saturating counters; halted cycles are not counted as stalls
    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (stall_out && (state_q != ST_HALTED) && (perf_stall_q != 16'hFFFF)) begin
            perf_stall_d = perf_stall_q + 16'd1;
        end
        if (flush_out && (perf_flush_q != 16'hFFFF)) begin
            perf_flush_d = perf_flush_q + 16'd1;
        end
    end

    // Performance counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= 16'd0;
            perf_flush_q <= 16'd0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall_out = perf_stall_q;
    assign perf_flush_out = perf_flush_q;
`else
    assign perf_stall_out = 16'd0;
    assign perf_flush_out = 16'd0;
`endif

endmodule

// File: tb/tb_decode_control_unit.sv
// tb_decode_control_unit
// Table-driven bench for decode_control_unit. Each vector drives one cycle of
// ID/EX inputs; the expected {control bundle, stall, flush, halted, illegal}
// is queued when driven and popped when the outputs are sampled on the
// falling edge. Hand-written sequences cover HALT, reset during MUL_WAIT and
// (when enabled) the performance counters.
module tb_decode_control_unit;

  localparam int RW   = 4;
  localparam int MULC = 3;

  // Control bundle bit order: {wbs, wme, mm, ALUop[1:0], wm, am, ni}
  localparam logic [7:0] C_BUB  = 8'b0000_0000;
  localparam logic [7:0] C_ADD  = 8'b0000_0100;
  localparam logic [7:0] C_SUB  = 8'b0000_1100;
  localparam logic [7:0] C_ADDI = 8'b0000_0110;
  localparam logic [7:0] C_LDR  = 8'b1010_0110;
  localparam logic [7:0] C_STR  = 8'b0100_0010;
  localparam logic [7:0] C_MUL  = 8'b0001_0100;
  localparam logic [7:0] C_SHL  = 8'b0001_1100;
  localparam logic [7:0] C_B    = 8'b0000_0001;

  typedef struct {
    string         name;
    logic          v;
    logic [3:0]    op;
    logic [RW-1:0] r1;
    logic [RW-1:0] r2;
    logic          mm;
    logic          wm;
    logic [RW-1:0] rd;
    logic          br;
    logic [11:0]   exp;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic          valid_in;
  logic [3:0]    opcode_in;
  logic [RW-1:0] rs1_in, rs2_in, ex_rd_in;
  logic          ex_mm_in, ex_wm_in, branch_taken_in;
  logic          wbs_out, wme_out, mm_out, wm_out, am_out, ni_out;
  logic [1:0]    ALUop_out;
  logic          stall_out, flush_out, halted_out, illegal_out;
  logic [15:0]   perf_stall_out, perf_flush_out;

  logic [11:0]   exp_q[$];
  vec_t          tbl[$];
  int            total;
  int            bad;

  decode_control_unit #(
    .REG_ADDR_W(RW),
    .MUL_CYCLES(MULC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_in       (valid_in),
    .opcode_in      (opcode_in),
    .rs1_in         (rs1_in),
    .rs2_in         (rs2_in),
    .ex_mm_in       (ex_mm_in),
    .ex_wm_in       (ex_wm_in),
    .ex_rd_in       (ex_rd_in),
    .branch_taken_in(branch_taken_in),
    .wbs_out        (wbs_out),
    .wme_out        (wme_out),
    .mm_out         (mm_out),
    .ALUop_out      (ALUop_out),
    .wm_out         (wm_out),
    .am_out         (am_out),
    .ni_out         (ni_out),
    .stall_out      (stall_out),
    .flush_out      (flush_out),
    .halted_out     (halted_out),
    .illegal_out    (illegal_out),
    .perf_stall_out (perf_stall_out),
    .perf_flush_out (perf_flush_out)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] ex(logic [7:0] c, logic st, logic fl, logic ha, logic il);
    return {c, st, fl, ha, il};
  endfunction

  function automatic vec_t mkv(string n, logic v, logic [3:0] op, logic [RW-1:0] r1,
                               logic [RW-1:0] r2, logic mm, logic wm, logic [RW-1:0] rd,
                               logic br, logic [11:0] e);
    vec_t t;
    t.name = n; t.v = v; t.op = op; t.r1 = r1; t.r2 = r2;
    t.mm = mm; t.wm = wm; t.rd = rd; t.br = br; t.exp = e;
    return t;
  endfunction

  function automatic logic [11:0] observed();
    return {wbs_out, wme_out, mm_out, ALUop_out, wm_out, am_out, ni_out,
            stall_out, flush_out, halted_out, illegal_out};
  endfunction

  task automatic drive(vec_t t);
    valid_in        = t.v;
    opcode_in       = t.op;
    rs1_in          = t.r1;
    rs2_in          = t.r2;
    ex_mm_in        = t.mm;
    ex_wm_in        = t.wm;
    ex_rd_in        = t.rd;
    branch_taken_in = t.br;
  endtask

  // Pop the oldest expectation and compare with the sampled outputs
  task automatic score(string name);
    logic [11:0] got, e;
    got = observed();
    e   = exp_q.pop_front();
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL %s got=%03h exp=%03h", name, got, e);
    end
  endtask

  task automatic check16(string name, logic [15:0] got, logic [15:0] e);
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL %s got=%04h exp=%04h", name, got, e);
    end
  endtask

  // One cycle: drive after the rising edge, sample on the falling edge
  task automatic apply(vec_t t);
    drive(t);
    exp_q.push_back(t.exp);
    @(negedge clk);
    score(t.name);
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(mkv("init", 0, 4'h0, 0, 0, 0, 0, 0, 0, 0));

    // Reset values: outputs follow RUN decode while in reset
    repeat (2) @(posedge clk);
    drive(mkv("rst_add", 1, 4'h1, 3, 5, 0, 0, 0, 0, 0));
    exp_q.push_back(ex(C_ADD, 0, 0, 0, 0));
    @(negedge clk);
    score("rst_add");
    check16("rst_perf_stall", perf_stall_out, 16'd0);
    check16("rst_perf_flush", perf_flush_out, 16'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    //               name         v  op    r1 r2 mm wm rd br expected
    tbl.push_back(mkv("idle",      0, 4'h1, 3, 5, 1, 1, 5, 0, ex(C_BUB, 0, 0, 0, 0)));
    tbl.push_back(mkv("lu_rs2",    1, 4'h1, 3, 5, 1, 1, 5, 0, ex(C_BUB, 1, 0, 0, 0)));
    tbl.push_back(mkv("lu_after",  1, 4'h1, 3, 5, 0, 0, 0, 0, ex(C_ADD, 0, 0, 0, 0)));
    tbl.push_back(mkv("lu_rd0",    1, 4'h1, 0, 0, 1, 1, 0, 0, ex(C_ADD, 0, 0, 0, 0)));
    tbl.push_back(mkv("addi_rs2",  1, 4'h3, 3, 5, 1, 1, 5, 0, ex(C_ADDI, 0, 0, 0, 0)));
    tbl.push_back(mkv("lu_rs1",    1, 4'h4, 5, 1, 1, 1, 5, 0, ex(C_BUB, 1, 0, 0, 0)));
    tbl.push_back(mkv("ldr",       1, 4'h4, 5, 1, 0, 0, 5, 0, ex(C_LDR, 0, 0, 0, 0)));
    tbl.push_back(mkv("str_nowm",  1, 4'h5, 1, 5, 1, 0, 5, 0, ex(C_STR, 0, 0, 0, 0)));
    tbl.push_back(mkv("sub",       1, 4'h2, 2, 3, 0, 1, 2, 0, ex(C_SUB, 0, 0, 0, 0)));
    tbl.push_back(mkv("shl",       1, 4'h7, 4, 6, 1, 0, 4, 0, ex(C_SHL, 0, 0, 0, 0)));
    tbl.push_back(mkv("lu_b",      1, 4'h8, 7, 2, 1, 1, 7, 0, ex(C_BUB, 1, 0, 0, 0)));
    tbl.push_back(mkv("b",         1, 4'h8, 7, 2, 0, 0, 7, 0, ex(C_B, 0, 0, 0, 0)));
    tbl.push_back(mkv("nop",       1, 4'h0, 7, 7, 1, 1, 7, 0, ex(C_BUB, 0, 0, 0, 0)));
    tbl.push_back(mkv("illegal9",  1, 4'h9, 1, 1, 0, 0, 0, 0, ex(C_BUB, 0, 0, 0, 1)));
    tbl.push_back(mkv("illegal_nv",0, 4'hC, 1, 1, 0, 0, 0, 0, ex(C_BUB, 0, 0, 0, 0)));
    tbl.push_back(mkv("ldr_rs2",   1, 4'h4, 2, 6, 1, 1, 6, 0, ex(C_LDR, 0, 0, 0, 0)));
    tbl.push_back(mkv("mul",       1, 4'h6, 1, 2, 0, 0, 0, 0, ex(C_MUL, 0, 0, 0, 0)));
    tbl.push_back(mkv("mul_w1",    1, 4'h1, 1, 2, 0, 0, 0, 0, ex(C_BUB, 1, 0, 0, 0)));
    tbl.push_back(mkv("mul_w2",    1, 4'h1, 1, 2, 0, 0, 0, 0, ex(C_BUB, 1, 0, 0, 0)));
    tbl.push_back(mkv("mul_next",  1, 4'h1, 1, 2, 0, 0, 0, 0, ex(C_ADD, 0, 0, 0, 0)));
    tbl.push_back(mkv("br_halt",   1, 4'hF, 0, 0, 0, 0, 0, 1, ex(C_BUB, 0, 1, 0, 0)));
    tbl.push_back(mkv("br_mul",    1, 4'h6, 1, 2, 0, 0, 0, 1, ex(C_BUB, 0, 1, 0, 0)));
    tbl.push_back(mkv("br_after",  1, 4'h1, 1, 2, 0, 0, 0, 0, ex(C_ADD, 0, 0, 0, 0)));
    tbl.push_back(mkv("mul2",      1, 4'h6, 1, 2, 0, 0, 0, 0, ex(C_MUL, 0, 0, 0, 0)));
    tbl.push_back(mkv("br_in_mw",  1, 4'h1, 1, 2, 0, 0, 0, 1, ex(C_BUB, 0, 1, 0, 0)));
    tbl.push_back(mkv("mw_killed", 1, 4'h1, 1, 2, 0, 0, 0, 0, ex(C_ADD, 0, 0, 0, 0)));

    foreach (tbl[i]) apply(tbl[i]);

    // Five non-halted stalls and three flushes in the table above
`ifdef PERF_COUNTERS_EN
    check16("perf_stall_tbl", perf_stall_out, 16'd5);
    check16("perf_flush_tbl", perf_flush_out, 16'd3);
`else
    check16("perf_stall_off", perf_stall_out, 16'd0);
    check16("perf_flush_off", perf_flush_out, 16'd0);
`endif

    // HALT decodes as a bubble; the core is halted from the next cycle on
    apply(mkv("halt", 1, 4'hF, 0, 0, 0, 0, 0, 0, ex(C_BUB, 0, 0, 0, 0)));
    for (int i = 0; i < 20; i++) begin
      vec_t t;
      t = mkv("halted", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              RW'($urandom_range(0, 15)), RW'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              RW'($urandom_range(0, 15)), 1'(i % 2), ex(C_BUB, 1, 0, 1, 0));
      apply(t);
    end
`ifdef PERF_COUNTERS_EN
    check16("perf_stall_halt", perf_stall_out, 16'd5);
`endif

    // Reset leaves HALTED
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    apply(mkv("post_halt_rst", 1, 4'h2, 1, 2, 0, 0, 0, 0, ex(C_SUB, 0, 0, 0, 0)));

    // Reset in the middle of MUL_WAIT, after one bubble
    apply(mkv("rmul",      1, 4'h6, 1, 2, 0, 0, 0, 0, ex(C_MUL, 0, 0, 0, 0)));
    apply(mkv("rmul_w1",   1, 4'h1, 1, 2, 0, 0, 0, 0, ex(C_BUB, 1, 0, 0, 0)));
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    apply(mkv("rmul_rst",  1, 4'h1, 1, 2, 0, 0, 0, 0, ex(C_ADD, 0, 0, 0, 0)));
    apply(mkv("rmul_next", 1, 4'h7, 1, 2, 0, 0, 0, 0, ex(C_SHL, 0, 0, 0, 0)));

`ifdef PERF_COUNTERS_EN
    check16("perf_stall_rst", perf_stall_out, 16'd0);
    // Held load-use hazard stalls every cycle; the counter must pin at 0xFFFF
    drive(mkv("sat", 1, 4'h1, 3, 5, 1, 1, 5, 0, ex(C_BUB, 1, 0, 0, 0)));
    repeat (65540) @(posedge clk);
    @(negedge clk);
    check16("perf_stall_sat", perf_stall_out, 16'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
